wb_ctrl: RTL and testbench

WB_CTRL -- requirements
Module: wb_ctrl

---
 rtl/wb_ctrl.sv | 147 ++++++++++++++
 tb/tb_wb_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl.sv
// Writeback controller: busy scoreboard, round-robin ALU/MEM result arbitration, registered RF write port.
// Optional write-port bypass on the hazard queries is enabled by defining WB_BYPASS_EN.
module wb_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd,
  output logic             iss_ready,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [WIDTH-1:0] alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic [WIDTH-1:0] mem_data,
  output logic             mem_ready,
  output logic             wr,
  output logic [4:0]       c_idx,
  output logic [WIDTH-1:0] c,
  input  logic [4:0]       q_a_idx,
  input  logic [4:0]       q_b_idx,
  output logic             q_a_busy,
  output logic             q_b_busy,
  output logic             fwd_a_valid,
  output logic [WIDTH-1:0] fwd_a_data,
  output logic             fwd_b_valid,
  output logic [WIDTH-1:0] fwd_b_data,
  output logic [5:0]       pend_cnt
);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

  function automatic logic [31:0] idx_onehot(input logic [4:0] idx);
    idx_onehot = 32'd1 << idx;
  endfunction

  logic [31:0]      r_busy;
  grant_e           r_last_grant;
  logic             r_wr_p1;
  logic [4:0]       r_c_idx_p1;
  logic [WIDTH-1:0] r_c_p1;
  logic [5:0]       r_pend_cnt;

  logic             w_alu_ready;
  logic             w_mem_ready;
  logic             w_alu_xfer;
  logic             w_mem_xfer;
  logic             w_xfer_p0;
  logic [4:0]       w_xfer_rd_p0;
  logic [WIDTH-1:0] w_xfer_data_p0;
  logic             w_set_en;
  logic             w_dec_en;
  logic [31:0]      w_set_vec;
  logic [31:0]      w_clr_vec;
  logic [31:0]      w_busy_nxt;
  logic [5:0]       w_pend_nxt;

  // Stage p0: arbitration between the two producers
  always_comb begin
    w_alu_ready = 1'b1;
    w_mem_ready = 1'b1;
    if (alu_valid && mem_valid) begin
      if (r_last_grant == GNT_ALU) w_alu_ready = 1'b0;
      else                         w_mem_ready = 1'b0;
    end else if (alu_valid) begin
      w_mem_ready = 1'b0;
    end else if (mem_valid) begin
      w_alu_ready = 1'b0;
    end
    w_alu_xfer     = alu_valid && w_alu_ready;
    w_mem_xfer     = mem_valid && w_mem_ready;
    w_xfer_p0      = w_alu_xfer || w_mem_xfer;
    w_xfer_rd_p0   = w_mem_xfer ? mem_rd : alu_rd;
    w_xfer_data_p0 = w_mem_xfer ? mem_data : alu_data;
  end

  assign alu_ready = w_alu_ready;
  assign mem_ready = w_mem_ready;

  // Scoreboard next state: a same-edge set overrides the clear from the write port
  always_comb begin
    w_set_en   = iss_valid && !r_busy[iss_rd] && (iss_rd != 5'd0);
    w_set_vec  = w_set_en ? idx_onehot(iss_rd) : 32'd0;
    w_clr_vec  = r_wr_p1 ? idx_onehot(r_c_idx_p1) : 32'd0;
    w_busy_nxt = ((r_busy & ~w_clr_vec) | w_set_vec) & ~32'd1;
    w_dec_en   = r_wr_p1 && r_busy[r_c_idx_p1] && !(w_set_en && (iss_rd == r_c_idx_p1));
    w_pend_nxt = r_pend_cnt;
    if (w_set_en && !w_dec_en)      w_pend_nxt = r_pend_cnt + 6'd1;
    else if (!w_set_en && w_dec_en) w_pend_nxt = r_pend_cnt - 6'd1;
  end

  assign iss_ready = !r_busy[iss_rd];

  // Stage p1: registered register-file write port
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_busy       <= 32'd0;
      r_pend_cnt   <= 6'd0;
      r_last_grant <= GNT_ALU;
      r_wr_p1      <= 1'b0;
      r_c_idx_p1   <= 5'd0;
      r_c_p1       <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= w_pend_nxt;
      if (w_alu_xfer)      r_last_grant <= GNT_ALU;
      else if (w_mem_xfer) r_last_grant <= GNT_MEM;
      r_wr_p1 <= w_xfer_p0 && (w_xfer_rd_p0 != 5'd0);
      if (w_xfer_p0 && (w_xfer_rd_p0 != 5'd0)) begin
        r_c_idx_p1 <= w_xfer_rd_p0;
        r_c_p1     <= w_xfer_data_p0;
      end
    end
  end

  assign wr       = r_wr_p1;
  assign c_idx    = r_c_idx_p1;
  assign c        = r_c_p1;
  assign pend_cnt = r_pend_cnt;

`ifdef WB_BYPASS_EN
  logic w_hit_a;
  logic w_hit_b;

  assign w_hit_a     = r_wr_p1 && (r_c_idx_p1 == q_a_idx) && (q_a_idx != 5'd0);
  assign w_hit_b     = r_wr_p1 && (r_c_idx_p1 == q_b_idx) && (q_b_idx != 5'd0);
  assign q_a_busy    = r_busy[q_a_idx] && !w_hit_a;
  assign q_b_busy    = r_busy[q_b_idx] && !w_hit_b;
  assign fwd_a_valid = w_hit_a;
  assign fwd_b_valid = w_hit_b;
  assign fwd_a_data  = w_hit_a ? r_c_p1 : '0;
  assign fwd_b_data  = w_hit_b ? r_c_p1 : '0;
`else
  assign q_a_busy    = r_busy[q_a_idx];
  assign q_b_busy    = r_busy[q_b_idx];
  assign fwd_a_valid = 1'b0;
  assign fwd_b_valid = 1'b0;
  assign fwd_a_data  = '0;
  assign fwd_b_data  = '0;
`endif

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed bench for wb_ctrl: scoreboard, arbitration, write port, reset and bypass behaviour.
module tb_wb_ctrl;
  localparam int WIDTH = 32;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             iss_valid = 1'b0;
  logic [4:0]       iss_rd = 5'd0;
  logic             iss_ready;
  logic             alu_valid = 1'b0;
  logic [4:0]       alu_rd = 5'd0;
  logic [WIDTH-1:0] alu_data = '0;
  logic             alu_ready;
  logic             mem_valid = 1'b0;
  logic [4:0]       mem_rd = 5'd0;
  logic [WIDTH-1:0] mem_data = '0;
  logic             mem_ready;
  logic             wr;
  logic [4:0]       c_idx;
  logic [WIDTH-1:0] c;
  logic [4:0]       q_a_idx = 5'd0;
  logic [4:0]       q_b_idx = 5'd0;
  logic             q_a_busy;
  logic             q_b_busy;
  logic             fwd_a_valid;
  logic [WIDTH-1:0] fwd_a_data;
  logic             fwd_b_valid;
  logic [WIDTH-1:0] fwd_b_data;
  logic [5:0]       pend_cnt;

  int checks = 0;
  int errors = 0;

  wb_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rstn(rstn),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wr(wr), .c_idx(c_idx), .c(c),
    .q_a_idx(q_a_idx), .q_b_idx(q_b_idx), .q_a_busy(q_a_busy), .q_b_busy(q_b_busy),
    .fwd_a_valid(fwd_a_valid), .fwd_a_data(fwd_a_data),
    .fwd_b_valid(fwd_b_valid), .fwd_b_data(fwd_b_data),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAA;
    tick();
    tick();
    alu_valid = 1'b0;
    iss_rd = 5'd5;
    #1;
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr got %0h exp 0", wr); end
    checks++; if (c_idx !== 5'd0) begin errors++; $display("FAIL reset_c_idx got %0h exp 0", c_idx); end
    checks++; if (c !== 32'd0) begin errors++; $display("FAIL reset_c got %0h exp 0", c); end
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL reset_pend got %0d exp 0", pend_cnt); end
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready got %0h exp 1", iss_ready); end
    checks++; if ({alu_ready, mem_ready} !== 2'b11) begin errors++; $display("FAIL idle_readies got %b exp 11", {alu_ready, mem_ready}); end
    rstn = 1'b1;
    tick();
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_discard_wr got %0h exp 0", wr); end
  endtask

  task automatic test_issue();
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0; q_a_idx = 5'd5;
    #1;
    checks++; if (q_a_busy !== 1'b1) begin errors++; $display("FAIL issue_q_a_busy got %0h exp 1", q_a_busy); end
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL issue_iss_ready got %0h exp 0", iss_ready); end
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL issue_pend got %0d exp 1", pend_cnt); end
    iss_rd = 5'd0;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL issue_rd0_ready got %0h exp 1", iss_ready); end
  endtask

  task automatic test_alu_wb();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    checks++; if ({alu_ready, mem_ready} !== 2'b10) begin errors++; $display("FAIL alu_only_readies got %b exp 10", {alu_ready, mem_ready}); end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++; if (wr !== 1'b1) begin errors++; $display("FAIL alu_wb_wr got %0h exp 1", wr); end
    checks++; if (c_idx !== 5'd5) begin errors++; $display("FAIL alu_wb_c_idx got %0d exp 5", c_idx); end
    checks++; if (c !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wb_c got %0h exp deadbeef", c); end
    checks++; if (q_a_busy !== !BYP) begin errors++; $display("FAIL wr_cycle_q_a_busy got %0h exp %0h", q_a_busy, !BYP); end
    tick();
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL alu_wb_wr_drop got %0h exp 0", wr); end
    checks++; if (c !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wb_c_hold got %0h exp deadbeef", c); end
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL alu_wb_pend got %0d exp 0", pend_cnt); end
    checks++; if (q_a_busy !== 1'b0) begin errors++; $display("FAIL alu_wb_busy_clr got %0h exp 0", q_a_busy); end
  endtask

  task automatic test_mem_only();
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    #1;
    checks++; if ({alu_ready, mem_ready} !== 2'b01) begin errors++; $display("FAIL mem_only_readies got %b exp 01", {alu_ready, mem_ready}); end
    tick();
    mem_valid = 1'b0;
    #1;
    checks++; if ({wr, c_idx} !== {1'b1, 5'd9}) begin errors++; $display("FAIL mem_wb_wr_idx got %0h exp %0h", {wr, c_idx}, {1'b1, 5'd9}); end
    checks++; if (c !== 32'h99) begin errors++; $display("FAIL mem_wb_c got %0h exp 99", c); end
    tick();
    q_a_idx = 5'd9;
    #1;
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL nonbusy_wr_pend got %0d exp 0", pend_cnt); end
    checks++; if (q_a_busy !== 1'b0) begin errors++; $display("FAIL nonbusy_wr_busy got %0h exp 0", q_a_busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_mem;
    exp_mem = 4'b0101;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({alu_ready, mem_ready} !== {!exp_mem[i], exp_mem[i]}) begin
        errors++; $display("FAIL rr_grant%0d got %b exp %b", i, {alu_ready, mem_ready}, {!exp_mem[i], exp_mem[i]});
      end
      tick();
      checks++;
      if ({wr, c_idx, c} !== {1'b1, (exp_mem[i] ? 5'd2 : 5'd1), (exp_mem[i] ? 32'hB2 : 32'hA1)}) begin
        errors++; $display("FAIL rr_write%0d got wr=%0h idx=%0d c=%0h", i, wr, c_idx, c);
      end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL rr_idle_wr got %0h exp 0", wr); end
    alu_valid = 1'b1; mem_valid = 1'b1;
    #1;
    checks++; if ({alu_ready, mem_ready} !== 2'b01) begin errors++; $display("FAIL rr_after_idle got %b exp 01", {alu_ready, mem_ready}); end
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL rr_pend got %0d exp 0", pend_cnt); end
  endtask

  task automatic test_set_wins();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    tick();
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    checks++; if ({wr, c_idx, iss_ready} !== {1'b1, 5'd7, 1'b1}) begin errors++; $display("FAIL setwin_setup got %0h exp %0h", {wr, c_idx, iss_ready}, {1'b1, 5'd7, 1'b1}); end
    tick();
    iss_valid = 1'b0; q_b_idx = 5'd7;
    #1;
    checks++; if (q_b_busy !== 1'b1) begin errors++; $display("FAIL setwin_busy got %0h exp 1", q_b_busy); end
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL setwin_pend got %0d exp 1", pend_cnt); end
    alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    tick();
    checks++; if (pend_cnt !== 6'd0) begin errors++; $display("FAIL setwin_clear_pend got %0d exp 0", pend_cnt); end
  endtask

  task automatic test_rd0();
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL rd0_accept got %0h exp 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL rd0_wr got %0h exp 0", wr); end
    tick();
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL rd0_pend got %0d exp 1", pend_cnt); end
  endtask

  task automatic test_bypass();
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    iss_valid = 1'b0;
    checks++; if (pend_cnt !== 6'd2) begin errors++; $display("FAIL byp_pend_pre got %0d exp 2", pend_cnt); end
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h55;
    tick();
    alu_valid = 1'b0; q_b_idx = 5'd3; q_a_idx = 5'd4;
    #1;
    checks++; if (fwd_b_valid !== BYP) begin errors++; $display("FAIL byp_fwd_b_valid got %0h exp %0h", fwd_b_valid, BYP); end
    checks++; if (fwd_b_data !== (BYP ? 32'h55 : 32'h0)) begin errors++; $display("FAIL byp_fwd_b_data got %0h exp %0h", fwd_b_data, (BYP ? 32'h55 : 32'h0)); end
    checks++; if (q_b_busy !== !BYP) begin errors++; $display("FAIL byp_q_b_busy got %0h exp %0h", q_b_busy, !BYP); end
    checks++; if ({q_a_busy, fwd_a_valid} !== 2'b10) begin errors++; $display("FAIL byp_a_nohit got %b exp 10", {q_a_busy, fwd_a_valid}); end
    tick();
    checks++; if ({q_b_busy, fwd_b_valid} !== 2'b00) begin errors++; $display("FAIL byp_after got %b exp 00", {q_b_busy, fwd_b_valid}); end
    checks++; if (pend_cnt !== 6'd1) begin errors++; $display("FAIL byp_pend_post got %0d exp 1", pend_cnt); end
  endtask

  initial begin
    test_reset();
    test_issue();
    test_alu_wb();
    test_mem_only();
    test_round_robin();
    test_set_wins();
    test_rd0();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
